rr_request_queue: RTL



---
 rtl/rr_sched_pkg.sv | 31 +++
 rtl/sat_counter.sv | 19 +
 rtl/rr_request_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - request word layout and stats width shared by the queue and rr_scheduling_kernel
package rr_sched_pkg;

  localparam int STATS_WIDTH = 16;

  function automatic int req_valid_bit(input int addr_width, input int value_width);
    return addr_width + value_width;
  endfunction

  function automatic int req_addr_lsb(input int addr_width, input int value_width);
    return value_width + (addr_width - addr_width);
  endfunction

  function automatic int req_value_lsb(input int addr_width, input int value_width);
    return (addr_width - addr_width) + (value_width - value_width);
  endfunction

  // Fields are masked to their widths; callers cast the result down to REQ_WIDTH.
  function automatic logic [63:0] pack_request(input int addr_width, input int value_width,
                                               input logic valid, input logic [31:0] addr,
                                               input logic [31:0] value);
    logic [63:0] amask;
    logic [63:0] vmask;
    amask = (64'd1 << addr_width) - 64'd1;
    vmask = (64'd1 << value_width) - 64'd1;
    return ({63'd0, valid} << req_valid_bit(addr_width, value_width))
         | (({32'd0, addr} & amask) << req_addr_lsb(addr_width, value_width))
         | (({32'd0, value} & vmask) << req_value_lsb(addr_width, value_width));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and asynchronous active-high reset
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (en && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rr_request_queue.sv
// rtl/rr_request_queue.sv - per-consumer request FIFO feeding rr_scheduling_kernel
// Optional stats counters enabled by RR_REQUEST_QUEUE_STATS_EN.
module rr_request_queue
  import rr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int DEPTH       = 4,
  localparam int REQ_WIDTH  = ADDR_WIDTH + VALUE_WIDTH + 1,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [ADDR_WIDTH-1:0]  push_addr,
  input  logic [VALUE_WIDTH-1:0] push_value,
  output logic [REQ_WIDTH-1:0]   request,
  input  logic                   grant,
`ifdef RR_REQUEST_QUEUE_STATS_EN
  output logic [STATS_WIDTH-1:0] grant_count,
  output logic [STATS_WIDTH-1:0] overflow_count,
`endif
  output logic [CNT_W-1:0]       count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ADDR_WIDTH + VALUE_WIDTH;
  localparam int VALID_BIT = req_valid_bit(ADDR_WIDTH, VALUE_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_nx;
  logic [CNT_W-1:0]     count_q, count_nx;
  logic [REQ_WIDTH-1:0] request_q, request_d;
  logic [ENTRY_W-1:0]   head_sel;
  logic                 do_push, do_pop;

  assign push_ready = (count_q < DEPTH_C) || ((count_q == DEPTH_C) && grant);
  assign do_push    = push_valid && push_ready;
  // Valid bit of the registered head is the only thing a grant can consume.
  assign do_pop     = grant && request_q[VALID_BIT];

  always_comb begin
    rd_nx    = rd_ptr + PTR_W'(do_pop);
    count_nx = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    head_sel = mem[rd_nx];
    if (do_push && (wr_ptr == rd_nx)) begin
      head_sel = {push_addr, push_value};
    end
    request_d = '0;
    if (count_nx != '0) begin
      request_d = REQ_WIDTH'(pack_request(ADDR_WIDTH, VALUE_WIDTH, 1'b1,
                                          32'(head_sel[ENTRY_W-1:VALUE_WIDTH]),
                                          32'(head_sel[VALUE_WIDTH-1:0])));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      request_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_nx;
      count_q   <= count_nx;
      request_q <= request_d;
    end
  end

  // Entry storage carries no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_addr, push_value};
    end
  end

  assign request = request_q;
  assign count   = count_q;

`ifdef RR_REQUEST_QUEUE_STATS_EN
  sat_counter #(.WIDTH(STATS_WIDTH)) u_grant_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (do_pop),
    .value (grant_count)
  );

  sat_counter #(.WIDTH(STATS_WIDTH)) u_overflow_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (push_valid && !push_ready),
    .value (overflow_count)
  );
`endif

endmodule
